// File: rtl/pcie_rx_credit.sv
// rtl/pcie_rx_credit.sv - VC0 receive TLP snooper returning PCIe flow-control credits
//
// Watches the 16-bit receive TLP stream, classifies each TLP from its header
// and returns posted / non-posted header and data credits as one-cycle pulses.
// Also keeps saturating per-class statistics counters.
//
// Ports:
//   clk_125      in   system clock
//   sys_rst      in   synchronous reset, active-high
//   rx_st        in   first word of a TLP
//   rx_end       in   last word of a TLP
//   rx_data      in   TLP word, upper half of DW0 first
//   ph_cr        out  release one posted header credit
//   pd_cr        out  release pd_num posted data credits
//   pd_num       out  posted data credit count (0 unless pd_cr)
//   nph_cr       out  release one non-posted header credit
//   npd_cr       out  release one non-posted data credit
//   stat_p_cnt   out  posted TLPs committed
//   stat_np_cnt  out  non-posted TLPs committed
//   stat_cpl_cnt out  completions committed
//   stat_err_cnt out  malformed or aborted TLPs

module pcie_rx_credit #(
    parameter int CNT_W = 16
) (
    input  logic             clk_125,
    input  logic             sys_rst,
    input  logic             rx_st,
    input  logic             rx_end,
    input  logic [15:0]      rx_data,
    output logic             ph_cr,
    output logic             pd_cr,
    output logic [7:0]       pd_num,
    output logic             nph_cr,
    output logic             npd_cr,
    output logic [CNT_W-1:0] stat_p_cnt,
    output logic [CNT_W-1:0] stat_np_cnt,
    output logic [CNT_W-1:0] stat_cpl_cnt,
    output logic [CNT_W-1:0] stat_err_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR1 = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // Credit event word: {split, ph, pd, nph, npd, pd_num[7:0]}.
    // 'split' marks a 256-credit return whose second half follows next cycle.
    localparam int EV_W = 13;
    localparam logic [EV_W-1:0] SPLIT_TAIL = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd128};

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [4:0]       type_q, type_d;
    logic [9:0]       len_q, len_d;
    logic             split_q, split_d;
    logic             pend_q, pend_d;
    logic [EV_W-1:0]  pend_ev_q, pend_ev_d;
    logic [EV_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0] p_cnt_q, np_cnt_q, cpl_cnt_q, err_cnt_q;

    logic             commit;
    logic             err_det;
    logic             has_data;
    logic             is_mem;
    logic             is_p;
    logic             is_np;
    logic             is_cpl;
    logic [9:0]       len_cur;
    logic [10:0]      lx;
    logic [10:0]      cr_sum;
    logic [8:0]       cr;
    logic [EV_W-1:0]  new_ev;
    logic             ev_valid;
    logic [2:0]       unused_bits;

    // Framing FSM. A new rx_st always restarts capture, whatever state we are in.
    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        type_d  = type_q;
        len_d   = len_q;
        commit  = 1'b0;
        err_det = 1'b0;
        if (rx_st && rx_end) begin
            err_det = 1'b1;
            state_d = S_IDLE;
        end else if (rx_st) begin
            err_det = (state_q != S_IDLE);
            fmt_d   = rx_data[14:13];
            type_d  = rx_data[12:8];
            state_d = S_HDR1;
        end else begin
            case (state_q)
                S_HDR1: begin
                    len_d   = rx_data[9:0];
                    commit  = rx_end;
                    state_d = rx_end ? S_IDLE : S_BODY;
                end
                S_BODY: begin
                    if (rx_end) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign has_data = fmt_q[1];
    assign is_mem   = (type_q == 5'b00000) || (type_q == 5'b00001);
    assign is_p     = (is_mem && has_data) || (type_q[4:3] == 2'b10);
    assign is_np    = (is_mem && !has_data) || (type_q == 5'b00010) ||
                      (type_q == 5'b00100) || (type_q == 5'b00101);
    assign is_cpl   = (type_q == 5'b01010) || (type_q == 5'b01011);

    // A 2-word TLP commits while its length word is still on the bus.
    assign len_cur  = (state_q == S_HDR1) ? rx_data[9:0] : len_q;
    assign lx       = (len_cur == 10'd0) ? 11'd1024 : {1'b0, len_cur};
    assign cr_sum   = lx + 11'd3;
    assign cr       = cr_sum[10:2];
    assign ev_valid = commit && (is_p || is_np);

    assign unused_bits = {rx_data[15], cr_sum[1:0]};

    always_comb begin
        new_ev = '0;
        if (commit && is_p) begin
            new_ev[11] = 1'b1;
            if (has_data) begin
                new_ev[10] = 1'b1;
                if (cr[8]) begin
                    new_ev[12]  = 1'b1;
                    new_ev[7:0] = 8'd128;
                end else begin
                    new_ev[7:0] = cr[7:0];
                end
            end
        end else if (commit && is_np) begin
            new_ev[9] = 1'b1;
            new_ev[8] = has_data;
        end
    end

    // Issue priority: split tail, then a parked event, then the fresh commit.
    always_comb begin
        out_d     = '0;
        pend_d    = pend_q;
        pend_ev_d = pend_ev_q;
        if (split_q) begin
            out_d = SPLIT_TAIL;
            if (ev_valid && !pend_q) begin
                pend_d    = 1'b1;
                pend_ev_d = new_ev;
            end
        end else if (pend_q) begin
            out_d     = pend_ev_q;
            pend_d    = ev_valid;
            pend_ev_d = new_ev;
        end else if (ev_valid) begin
            out_d = new_ev;
        end
        split_d = out_d[12];
    end

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            fmt_q     <= '0;
            type_q    <= '0;
            len_q     <= '0;
            split_q   <= 1'b0;
            pend_q    <= 1'b0;
            pend_ev_q <= '0;
            out_q     <= '0;
            p_cnt_q   <= '0;
            np_cnt_q  <= '0;
            cpl_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fmt_q     <= fmt_d;
            type_q    <= type_d;
            len_q     <= len_d;
            split_q   <= split_d;
            pend_q    <= pend_d;
            pend_ev_q <= pend_ev_d;
            out_q     <= out_d;
            if (commit && is_p && p_cnt_q != CNT_MAX)
                p_cnt_q <= p_cnt_q + CNT_ONE;
            if (commit && is_np && np_cnt_q != CNT_MAX)
                np_cnt_q <= np_cnt_q + CNT_ONE;
            if (commit && is_cpl && cpl_cnt_q != CNT_MAX)
                cpl_cnt_q <= cpl_cnt_q + CNT_ONE;
            if ((err_det || (commit && !is_p && !is_np && !is_cpl)) && err_cnt_q != CNT_MAX)
                err_cnt_q <= err_cnt_q + CNT_ONE;
        end
    end

    assign ph_cr        = out_q[11];
    assign pd_cr        = out_q[10];
    assign nph_cr       = out_q[9];
    assign npd_cr       = out_q[8];
    assign pd_num       = out_q[7:0];
    assign stat_p_cnt   = p_cnt_q;
    assign stat_np_cnt  = np_cnt_q;
    assign stat_cpl_cnt = cpl_cnt_q;
    assign stat_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pcie_rx_credit.sv
// tb/tb_pcie_rx_credit.sv - self-checking bench for pcie_rx_credit

module tb_pcie_rx_credit;

    logic clk_125 = 1'b0;
    always #4 clk_125 = ~clk_125;

    logic        sys_rst, rx_st, rx_end;
    logic [15:0] rx_data;

    logic        ph_cr, pd_cr, nph_cr, npd_cr;
    logic [7:0]  pd_num;
    logic [15:0] stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt;

    logic        s_ph_cr, s_pd_cr, s_nph_cr, s_npd_cr;
    logic [7:0]  s_pd_num;
    logic [3:0]  s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt;

    pcie_rx_credit #(.CNT_W(16)) dut (
        .clk_125(clk_125), .sys_rst(sys_rst), .rx_st(rx_st), .rx_end(rx_end), .rx_data(rx_data),
        .ph_cr(ph_cr), .pd_cr(pd_cr), .pd_num(pd_num), .nph_cr(nph_cr), .npd_cr(npd_cr),
        .stat_p_cnt(stat_p_cnt), .stat_np_cnt(stat_np_cnt),
        .stat_cpl_cnt(stat_cpl_cnt), .stat_err_cnt(stat_err_cnt)
    );

    // Narrow-counter instance so saturation is reached in a short run.
    pcie_rx_credit #(.CNT_W(4)) dut_s (
        .clk_125(clk_125), .sys_rst(sys_rst), .rx_st(rx_st), .rx_end(rx_end), .rx_data(rx_data),
        .ph_cr(s_ph_cr), .pd_cr(s_pd_cr), .pd_num(s_pd_num), .nph_cr(s_nph_cr), .npd_cr(s_npd_cr),
        .stat_p_cnt(s_p_cnt), .stat_np_cnt(s_np_cnt),
        .stat_cpl_cnt(s_cpl_cnt), .stat_err_cnt(s_err_cnt)
    );

    int checks, errors, now;
    int m_p, m_np, m_cpl, m_err;

    // Credit pulses per cycle: {ph, pd, nph, npd, pd_num}
    logic [11:0] exp_ev [int];
    logic [11:0] obs    [int];

    always @(negedge clk_125) obs[now] = {ph_cr, pd_cr, nph_cr, npd_cr, pd_num};

    // ---------------- reference model ----------------
    function automatic logic [3:0] sat4(input int v);
        logic [3:0] r;
        r = (v > 15) ? 4'hF : 4'(v);
        return r;
    endfunction

    function automatic logic [63:0] exp_c16();
        return {16'(m_p), 16'(m_np), 16'(m_cpl), 16'(m_err)};
    endfunction

    function automatic logic [15:0] exp_c4();
        return {sat4(m_p), sat4(m_np), sat4(m_cpl), sat4(m_err)};
    endfunction

    // TLP whose rx_end is driven in cycle k.
    function automatic void model_commit(input logic [1:0] fmt, input logic [4:0] ty,
                                         input logic [9:0] len, input int k);
        logic [11:0] e1, e2;
        int dw, cr, s;
        bit posted, nonp;
        e1 = '0;
        e2 = '0;
        posted = ((ty == 5'd0 || ty == 5'd1) && fmt[1]) || (ty >= 5'd16 && ty <= 5'd23);
        nonp   = ((ty == 5'd0 || ty == 5'd1) && !fmt[1]) || ty == 5'd2 || ty == 5'd4 || ty == 5'd5;
        if (posted) begin
            m_p++;
            e1[11] = 1'b1;
            if (fmt[1]) begin
                dw = (len == 10'd0) ? 1024 : int'(len);
                cr = (dw + 3) / 4;
                e1[10] = 1'b1;
                if (cr == 256) begin
                    e1[7:0] = 8'd128;
                    e2 = {4'b0100, 8'd128};
                end else begin
                    e1[7:0] = 8'(cr);
                end
            end
        end else if (nonp) begin
            m_np++;
            e1[9] = 1'b1;
            e1[8] = fmt[1];
        end else if (ty == 5'd10 || ty == 5'd11) begin
            m_cpl++;
        end else begin
            m_err++;
        end
        if (e1 != 12'h0) begin
            s = k + 1;
            while (exp_ev.exists(s)) s++;
            exp_ev[s] = e1;
            if (e2 != 12'h0) exp_ev[s + 1] = e2;
        end
    endfunction

    // Reset applied in cycle r: nothing scheduled after it survives.
    function automatic void model_reset(input int r);
        m_p = 0; m_np = 0; m_cpl = 0; m_err = 0;
        for (int c = r + 1; c <= r + 8; c++)
            if (exp_ev.exists(c)) exp_ev.delete(c);
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic en, input logic [15:0] d);
        rx_st = st;
        rx_end = en;
        rx_data = d;
        @(posedge clk_125);
        #1;
        now++;
        rx_st = 1'b0;
        rx_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'($urandom));
    endtask

    function automatic logic [15:0] hdr0(input logic [1:0] fmt, input logic [4:0] ty);
        logic b15;
        b15 = 1'($urandom);
        return {b15, fmt, ty, 8'($urandom)};
    endfunction

    task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] ty,
                            input logic [9:0] len, input int nw);
        drive(1'b1, 1'b0, hdr0(fmt, ty));
        for (int i = 1; i < nw; i++) begin
            if (i == nw - 1) model_commit(fmt, ty, len, now);
            drive(1'b0, i == nw - 1, (i == 1) ? {6'($urandom), len} : 16'($urandom));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst = 1'b1;
        idle(3);
        sys_rst = 1'b0;
        checks++;
        if ({ph_cr, pd_cr, nph_cr, npd_cr, pd_num} !== 12'h000) begin
            errors++;
            $display("FAIL reset_pulses got=%03h want=000", {ph_cr, pd_cr, nph_cr, npd_cr, pd_num});
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL reset_counters got=%016h want=0", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt});
        end
    endtask

    task automatic test_mwr();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        send_tlp(2'b10, 5'd0, 10'd1, 6);
        idle(3);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL mwr_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL mwr_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_split();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        send_tlp(2'b10, 5'd0, 10'd0, 4);
        idle(2);
        send_tlp(2'b11, 5'd1, 10'd1020, 3);
        send_tlp(2'b10, 5'd0, 10'd1021, 2);
        send_tlp(2'b10, 5'd0, 10'd1023, 2);
        idle(4);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL split_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL split_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_np_back_to_back();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        send_tlp(2'b00, 5'd0, 10'd1, 4);
        send_tlp(2'b10, 5'd4, 10'd1, 2);
        send_tlp(2'b00, 5'd2, 10'd1, 2);
        idle(3);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL np_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL np_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_cpl_msg();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        send_tlp(2'b10, 5'd10, 10'd4, 8);
        send_tlp(2'b01, 5'd16, 10'd0, 4);
        send_tlp(2'b11, 5'd19, 10'd5, 3);
        idle(3);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL cplmsg_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL cplmsg_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_errors();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        drive(1'b1, 1'b1, hdr0(2'b10, 5'd0));
        m_err++;
        idle(1);
        drive(1'b0, 1'b1, 16'($urandom));
        idle(1);
        // MWr aborted in BODY by a new rx_st; only the second MWr returns credit
        drive(1'b1, 1'b0, hdr0(2'b10, 5'd0));
        drive(1'b0, 1'b0, {6'h0, 10'd8});
        drive(1'b0, 1'b0, 16'($urandom));
        m_err++;
        drive(1'b1, 1'b0, hdr0(2'b10, 5'd0));
        drive(1'b0, 1'b0, {6'h0, 10'd4});
        model_commit(2'b10, 5'd0, 10'd4, now);
        drive(1'b0, 1'b1, 16'($urandom));
        send_tlp(2'b00, 5'd3, 10'd1, 3);
        idle(3);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL err_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL err_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [11:0] got, want;
        t0 = now;
        drive(1'b1, 1'b0, hdr0(2'b10, 5'd0));
        drive(1'b0, 1'b0, {6'h0, 10'd16});
        drive(1'b0, 1'b0, 16'($urandom));
        model_reset(now);
        sys_rst = 1'b1;
        drive(1'b0, 1'b0, 16'($urandom));
        sys_rst = 1'b0;
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL rstmid_cnt_clear got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
        drive(1'b0, 1'b0, 16'($urandom));
        drive(1'b0, 1'b1, 16'($urandom));
        idle(1);
        send_tlp(2'b10, 5'd0, 10'd0, 2);
        model_reset(now);
        sys_rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        sys_rst = 1'b0;
        idle(1);
        send_tlp(2'b10, 5'd0, 10'd8, 4);
        idle(3);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL rstmid_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL rstmid_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
    endtask

    task automatic test_random();
        int t0;
        logic [11:0] got, want;
        logic [4:0]  types [12];
        logic [9:0]  lens  [6];
        logic [9:0]  len;
        types = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd16, 5'd21, 5'd10, 5'd11, 5'd3, 5'd8, 5'd0};
        lens  = '{10'd0, 10'd1, 10'd1020, 10'd1021, 10'd1023, 10'd2};
        t0 = now;
        for (int n = 0; n < 60; n++) begin
            len = ($urandom_range(0, 1) == 0) ? lens[$urandom_range(0, 5)] : 10'($urandom);
            send_tlp(2'($urandom), types[$urandom_range(0, 11)], len, $urandom_range(2, 6));
            idle($urandom_range(0, 2));
        end
        idle(4);
        for (int c = t0; c < now; c++) begin
            want = exp_ev.exists(c) ? exp_ev[c] : 12'h000;
            got = obs.exists(c) ? obs[c] : 12'hxxx;
            checks++;
            if (got !== want) begin errors++; $display("FAIL random_pulses cyc=%0d got=%03h want=%03h", c, got, want); end
        end
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL random_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
        checks++;
        if ({s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt} !== exp_c4()) begin
            errors++; $display("FAIL random_cnt4 got=%04h want=%04h", {s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt}, exp_c4());
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 1'b1, hdr0(2'b00, 5'd0));
            m_err++;
        end
        idle(2);
        checks++;
        if ({stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt} !== exp_c16()) begin
            errors++; $display("FAIL sat_cnt16 got=%016h want=%016h", {stat_p_cnt, stat_np_cnt, stat_cpl_cnt, stat_err_cnt}, exp_c16());
        end
        checks++;
        if ({s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt} !== exp_c4()) begin
            errors++; $display("FAIL sat_cnt4 got=%04h want=%04h", {s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt}, exp_c4());
        end
        send_tlp(2'b10, 5'd0, 10'd8, 2);
        send_tlp(2'b00, 5'd0, 10'd8, 2);
        idle(2);
        checks++;
        if ({s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt} !== exp_c4()) begin
            errors++; $display("FAIL sat_hold_cnt4 got=%04h want=%04h", {s_p_cnt, s_np_cnt, s_cpl_cnt, s_err_cnt}, exp_c4());
        end
    endtask

    initial begin
        checks = 0; errors = 0; now = 0;
        m_p = 0; m_np = 0; m_cpl = 0; m_err = 0;
        sys_rst = 1'b1; rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'h0;
        test_reset();
        test_mwr();
        test_split();
        test_np_back_to_back();
        test_cpl_msg();
        test_errors();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
